// File: rtl/uart_rx_cmd_ctrl.sv
// uart_rx_cmd_ctrl: command decoder between the UART receiver, the register
// file and the UART transmitter.
// Frames: AA addr data (write), BB addr (read, byte returned via TX),
// CC cfg (receiver config). Bad opcodes and line errors bump err_count.
// Optional: define CTRL_TIMEOUT_EN to abort partial commands after
// TIMEOUT_CYCLES idle clocks; without it partial commands wait forever.
`timescale 1ns/1ps

module uart_rx_cmd_ctrl #(
    parameter logic [7:0] DEF_CFG        = 8'h21,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rx_data_valid,
    input  logic [7:0] rx_p_data,
    input  logic       rx_frame_err,
    output logic       wr_en,
    output logic       rd_en,
    output logic [7:0] addr,
    output logic [7:0] wr_data,
    input  logic [7:0] rd_data,
    input  logic       rd_data_valid,
    output logic [7:0] tx_data,
    output logic       tx_data_valid,
    input  logic       tx_busy,
    output logic       parity_en,
    output logic       parity_type,
    output logic [4:0] prescale,
    output logic [7:0] err_count
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        TX_SEND,
        CFG_DATA
    } state_t;

    localparam logic [7:0] OP_WR  = 8'hAA;
    localparam logic [7:0] OP_RD  = 8'hBB;
    localparam logic [7:0] OP_CFG = 8'hCC;

    state_t     state, state_next;
    logic [7:0] cfg, cfg_next;
    logic [7:0] addr_next, wr_data_next, tx_data_next;
    logic       wr_en_next, rd_en_next, tx_valid_next;
    logic       err_inc;
    logic       byte_ok;   // good byte with no simultaneous line error
    logic       take;      // byte actually consumed by the command path
    logic       timeout;

    assign byte_ok = rx_data_valid & ~rx_frame_err;
    assign take    = byte_ok & ~timeout;

    // Receiver configuration fields; cfg[7] is spare.
    assign parity_en   = cfg[0];
    assign parity_type = cfg[1];
    assign prescale    = cfg[6:2];

`ifdef CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             timed_state;

    assign timed_state = (state == WR_ADDR) || (state == WR_DATA) ||
                         (state == RD_ADDR) || (state == CFG_DATA);
    assign timeout     = timed_state && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));

    // Inter-byte idle counter; restarts on state entry and on every byte.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tmo_cnt <= '0;
        end else if (!timed_state || (state_next != state) || rx_data_valid) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: clocked state uses non-blocking (<=) so every flop samples
        // pre-edge values regardless of block ordering.
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and error-event decode; line errors override byte traffic.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        state_next = state;
        err_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (byte_ok) begin
                    case (rx_p_data)
                        OP_WR:   state_next = WR_ADDR;
                        OP_RD:   state_next = RD_ADDR;
                        OP_CFG:  state_next = CFG_DATA;
                        default: err_inc    = 1'b1;
                    endcase
                end
            end
            WR_ADDR:  if (byte_ok) state_next = WR_DATA;
            WR_DATA:  if (byte_ok) state_next = IDLE;
            RD_ADDR:  if (byte_ok) state_next = RD_WAIT;
            RD_WAIT: begin
                if (byte_ok)       err_inc    = 1'b1;
                if (rd_data_valid) state_next = TX_SEND;
            end
            TX_SEND: begin
                if (byte_ok)  err_inc    = 1'b1;
                if (!tx_busy) state_next = IDLE;
            end
            CFG_DATA: if (byte_ok) state_next = IDLE;
            default:  state_next = IDLE;
        endcase

        if (rx_frame_err) begin
            // The read/transmit leg is never aborted by a line error.
            err_inc = 1'b1;
            if (state != RD_WAIT && state != TX_SEND) begin
                state_next = IDLE;
            end
        end else if (timeout) begin
            err_inc    = 1'b1;
            state_next = IDLE;
        end
    end

    // Output decode: next values for strobes, latched fields and cfg.
    always_comb begin
        wr_en_next    = 1'b0;
        rd_en_next    = 1'b0;
        tx_valid_next = tx_data_valid;
        addr_next     = addr;
        wr_data_next  = wr_data;
        tx_data_next  = tx_data;
        cfg_next      = cfg;
        case (state)
            WR_ADDR: if (take) addr_next = rx_p_data;
            WR_DATA: begin
                if (take) begin
                    wr_data_next = rx_p_data;
                    wr_en_next   = 1'b1;
                end
            end
            RD_ADDR: begin
                if (take) begin
                    addr_next  = rx_p_data;
                    rd_en_next = 1'b1;
                end
            end
            RD_WAIT: begin
                if (rd_data_valid) begin
                    tx_data_next  = rd_data;
                    tx_valid_next = 1'b1;
                end
            end
            TX_SEND:  if (!tx_busy) tx_valid_next = 1'b0;
            CFG_DATA: if (take) cfg_next = rx_p_data;
            default: ;
        endcase
    end

    // Registered outputs and configuration byte.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_en         <= 1'b0;
            rd_en         <= 1'b0;
            tx_data_valid <= 1'b0;
            addr          <= '0;
            wr_data       <= '0;
            tx_data       <= '0;
            cfg           <= DEF_CFG;
        end else begin
            wr_en         <= wr_en_next;
            rd_en         <= rd_en_next;
            tx_data_valid <= tx_valid_next;
            addr          <= addr_next;
            wr_data       <= wr_data_next;
            tx_data       <= tx_data_next;
            cfg           <= cfg_next;
        end
    end

    // Saturating error counter, at most one step per cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_count <= '0;
        end else if (err_inc && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Directed self-checking bench for uart_rx_cmd_ctrl.
// Inputs change on the falling edge, outputs are checked on the falling edge.
// With CTRL_TIMEOUT_EN the timeout path is exercised (TIMEOUT_CYCLES = 100);
// without it the bench checks that a partial command waits indefinitely.
`timescale 1ns/1ps

module tb_uart_rx_cmd_ctrl;

    localparam int TMO = 100;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       rx_data_valid = 1'b0;
    logic [7:0] rx_p_data = '0;
    logic       rx_frame_err = 1'b0;
    logic       wr_en, rd_en;
    logic [7:0] addr, wr_data;
    logic [7:0] rd_data = '0;
    logic       rd_data_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_busy = 1'b0;
    logic       parity_en, parity_type;
    logic [4:0] prescale;
    logic [7:0] err_count;

    int errors = 0;
    int checks = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;

    uart_rx_cmd_ctrl #(
        .DEF_CFG       (8'h21),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .rx_data_valid(rx_data_valid),
        .rx_p_data    (rx_p_data),
        .rx_frame_err (rx_frame_err),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .addr         (addr),
        .wr_data      (wr_data),
        .rd_data      (rd_data),
        .rd_data_valid(rd_data_valid),
        .tx_data      (tx_data),
        .tx_data_valid(tx_data_valid),
        .tx_busy      (tx_busy),
        .parity_en    (parity_en),
        .parity_type  (parity_type),
        .prescale     (prescale),
        .err_count    (err_count)
    );

    always #5 CLK = ~CLK;

    // Count strobe-high cycles (pre-edge values) for exact pulse-count checks.
    always @(posedge CLK) begin
        if (wr_en) wr_pulses++;
        if (rd_en) rd_pulses++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_valid = 1'b1;
        rx_p_data     = b;
        @(negedge CLK);
        rx_data_valid = 1'b0;
    endtask

    task automatic frame_err_pulse();
        rx_frame_err = 1'b1;
        @(negedge CLK);
        rx_frame_err = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        idle(2);
        RST = 1'b1;
        idle(1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({wr_en, rd_en, tx_data_valid} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b want 000", {wr_en, rd_en, tx_data_valid}); end
        checks++; if ({addr, wr_data, tx_data} !== 24'h0) begin errors++; $display("FAIL reset_data: got %h want 000000", {addr, wr_data, tx_data}); end
        checks++; if ({parity_en, parity_type, prescale} !== {1'b1, 1'b0, 5'd8}) begin errors++; $display("FAIL reset_cfg: got en=%b type=%b pre=%0d want 1 0 8", parity_en, parity_type, prescale); end
        checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL reset_errcnt: got %h want 00", err_count); end
    endtask

    task automatic test_write();
        int w0;
        w0 = wr_pulses;
        send_byte(8'hAA);
        send_byte(8'h05);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL wr_early: got %b want 0", wr_en); end
        send_byte(8'h3C);
        checks++; if ({wr_en, addr, wr_data} !== {1'b1, 8'h05, 8'h3C}) begin errors++; $display("FAIL wr_strobe: got en=%b addr=%h data=%h want 1 05 3C", wr_en, addr, wr_data); end
        idle(1);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL wr_drop: got %b want 0", wr_en); end
        idle(2);
        checks++; if (wr_pulses - w0 !== 1) begin errors++; $display("FAIL wr_count: got %0d want 1", wr_pulses - w0); end
        // An unknown opcode right after proves the write returned to IDLE.
        send_byte(8'h3C);
        checks++; if (err_count !== 8'h01) begin errors++; $display("FAIL wr_idle: got %h want 01", err_count); end
    endtask

    task automatic test_read();
        int r0;
        int bad;
        do_reset();
        r0 = rd_pulses;
        send_byte(8'hBB);
        send_byte(8'h07);
        checks++; if ({rd_en, addr} !== {1'b1, 8'h07}) begin errors++; $display("FAIL rd_strobe: got en=%b addr=%h want 1 07", rd_en, addr); end
        idle(1);
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL rd_drop: got %b want 0", rd_en); end
        rd_data = 8'h5A; rd_data_valid = 1'b1; tx_busy = 1'b1;
        @(negedge CLK);
        rd_data_valid = 1'b0; rd_data = 8'h00;
        checks++; if ({tx_data_valid, tx_data} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL rd_tx: got v=%b d=%h want 1 5A", tx_data_valid, tx_data); end
        bad = 0;
        repeat (9) begin
            @(negedge CLK);
            if (tx_data_valid !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rd_hold: got %0d low cycles want 0", bad); end
        tx_busy = 1'b0;
        checks++; if (tx_data_valid !== 1'b1) begin errors++; $display("FAIL rd_hs_cycle: got %b want 1", tx_data_valid); end
        @(negedge CLK);
        checks++; if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL rd_release: got %b want 0", tx_data_valid); end
        checks++; if (rd_pulses - r0 !== 1) begin errors++; $display("FAIL rd_count: got %0d want 1", rd_pulses - r0); end
    endtask

    task automatic test_config();
        send_byte(8'hCC);
        send_byte(8'h41);
        checks++; if ({parity_en, parity_type, prescale} !== {1'b1, 1'b0, 5'd16}) begin errors++; $display("FAIL cfg_41: got en=%b type=%b pre=%0d want 1 0 16", parity_en, parity_type, prescale); end
        send_byte(8'hCC);
        send_byte(8'h20);
        checks++; if ({parity_en, parity_type, prescale} !== {1'b0, 1'b0, 5'd8}) begin errors++; $display("FAIL cfg_20: got en=%b type=%b pre=%0d want 0 0 8", parity_en, parity_type, prescale); end
        send_byte(8'hCC);
        send_byte(8'hA3);
        checks++; if ({parity_en, parity_type, prescale} !== {1'b1, 1'b1, 5'd8}) begin errors++; $display("FAIL cfg_A3: got en=%b type=%b pre=%0d want 1 1 8", parity_en, parity_type, prescale); end
        checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL cfg_noerr: got %h want 00", err_count); end
    endtask

    task automatic test_errors();
        int w0;
        do_reset();
        w0 = wr_pulses;
        send_byte(8'hAA);
        send_byte(8'h05);
        frame_err_pulse();
        idle(2);
        checks++; if (err_count !== 8'h01) begin errors++; $display("FAIL err_abort_cnt: got %h want 01", err_count); end
        checks++; if (wr_pulses - w0 !== 0) begin errors++; $display("FAIL err_abort_wr: got %0d strobes want 0", wr_pulses - w0); end
        send_byte(8'h12);
        checks++; if (err_count !== 8'h02) begin errors++; $display("FAIL err_badop: got %h want 02", err_count); end
        // Error and opcode together: error wins, AA ignored, so 05 is a bad opcode.
        rx_frame_err = 1'b1;
        send_byte(8'hAA);
        rx_frame_err = 1'b0;
        checks++; if (err_count !== 8'h03) begin errors++; $display("FAIL err_prio: got %h want 03", err_count); end
        send_byte(8'h05);
        checks++; if (err_count !== 8'h04) begin errors++; $display("FAIL err_prio_idle: got %h want 04", err_count); end
        // Stray rd_data_valid in IDLE is ignored.
        rd_data = 8'h99; rd_data_valid = 1'b1;
        @(negedge CLK);
        rd_data_valid = 1'b0;
        idle(1);
        checks++; if ({tx_data_valid, tx_data} !== {1'b0, 8'h00}) begin errors++; $display("FAIL err_stray_rdv: got v=%b d=%h want 0 00", tx_data_valid, tx_data); end
        // Errors during the read leg count but do not abort it.
        send_byte(8'hBB);
        send_byte(8'h07);
        frame_err_pulse();
        send_byte(8'h44);
        checks++; if (err_count !== 8'h06) begin errors++; $display("FAIL err_rdwait: got %h want 06", err_count); end
        rd_data = 8'h77; rd_data_valid = 1'b1; tx_busy = 1'b1;
        @(negedge CLK);
        rd_data_valid = 1'b0;
        frame_err_pulse();
        checks++; if ({tx_data_valid, tx_data, err_count} !== {1'b1, 8'h77, 8'h07}) begin errors++; $display("FAIL err_txsend: got v=%b d=%h cnt=%h want 1 77 07", tx_data_valid, tx_data, err_count); end
        tx_busy = 1'b0;
        idle(2);
        checks++; if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL err_tx_done: got %b want 0", tx_data_valid); end
        // Saturation: 200 pulses -> 207 (CF), 100 more -> FF, no wrap.
        rx_frame_err = 1'b1;
        idle(200);
        checks++; if (err_count !== 8'hCF) begin errors++; $display("FAIL err_count_run: got %h want CF", err_count); end
        idle(100);
        rx_frame_err = 1'b0;
        checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL err_sat: got %h want FF", err_count); end
        send_byte(8'h12);
        checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL err_nowrap: got %h want FF", err_count); end
    endtask

`ifdef CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int w0;
        do_reset();
        w0 = wr_pulses;
        send_byte(8'hAA);
        idle(TMO - 1);
        checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL tmo_early: got %h want 00", err_count); end
        idle(3);
        checks++; if (err_count !== 8'h01) begin errors++; $display("FAIL tmo_fire: got %h want 01", err_count); end
        send_byte(8'h3C);
        idle(2);
        checks++; if (err_count !== 8'h02) begin errors++; $display("FAIL tmo_badop: got %h want 02", err_count); end
        checks++; if (wr_pulses - w0 !== 0) begin errors++; $display("FAIL tmo_nowr: got %0d strobes want 0", wr_pulses - w0); end
    endtask
`else
    task automatic test_no_timeout();
        do_reset();
        send_byte(8'hAA);
        idle(3 * TMO);
        checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL wait_noerr: got %h want 00", err_count); end
        send_byte(8'h05);
        send_byte(8'h3C);
        checks++; if ({wr_en, addr, wr_data} !== {1'b1, 8'h05, 8'h3C}) begin errors++; $display("FAIL wait_wr: got en=%b addr=%h data=%h want 1 05 3C", wr_en, addr, wr_data); end
    endtask
`endif

    task automatic test_async_reset();
        int w0;
        do_reset();
        send_byte(8'hCC);
        send_byte(8'h41);
        checks++; if (prescale !== 5'd16) begin errors++; $display("FAIL ar_cfg_set: got %0d want 16", prescale); end
        send_byte(8'hAA);
        send_byte(8'h05);
        // Mid-cycle assertion, away from any clock edge.
        #2 RST = 1'b0;
        #1;
        checks++; if ({wr_en, rd_en, tx_data_valid, addr, wr_data, tx_data, err_count} !== 35'h0) begin errors++; $display("FAIL ar_outputs: got wr=%b rd=%b tv=%b a=%h w=%h t=%h e=%h want all 0", wr_en, rd_en, tx_data_valid, addr, wr_data, tx_data, err_count); end
        checks++; if ({parity_en, parity_type, prescale} !== {1'b1, 1'b0, 5'd8}) begin errors++; $display("FAIL ar_cfg: got en=%b type=%b pre=%0d want 1 0 8", parity_en, parity_type, prescale); end
        @(negedge CLK);
        RST = 1'b1;
        w0 = wr_pulses;
        idle(3);
        checks++; if (wr_pulses - w0 !== 0) begin errors++; $display("FAIL ar_residual: got %0d strobes want 0", wr_pulses - w0); end
        send_byte(8'hAA);
        send_byte(8'h11);
        send_byte(8'h22);
        checks++; if ({wr_en, addr, wr_data} !== {1'b1, 8'h11, 8'h22}) begin errors++; $display("FAIL ar_recover: got en=%b addr=%h data=%h want 1 11 22", wr_en, addr, wr_data); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h02);
        checks++; if ({wr_en, addr, wr_data} !== {1'b1, 8'h01, 8'h02}) begin errors++; $display("FAIL b2b_wr: got en=%b addr=%h data=%h want 1 01 02", wr_en, addr, wr_data); end
        send_byte(8'hBB);
        send_byte(8'h03);
        checks++; if ({rd_en, wr_en, addr} !== {1'b1, 1'b0, 8'h03}) begin errors++; $display("FAIL b2b_rd: got rd=%b wr=%b addr=%h want 1 0 03", rd_en, wr_en, addr); end
        rd_data = 8'hC3; rd_data_valid = 1'b1;
        @(negedge CLK);
        rd_data_valid = 1'b0;
        checks++; if ({tx_data_valid, tx_data} !== {1'b1, 8'hC3}) begin errors++; $display("FAIL b2b_tx: got v=%b d=%h want 1 C3", tx_data_valid, tx_data); end
        @(negedge CLK);
        checks++; if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL b2b_tx_drop: got %b want 0", tx_data_valid); end
        send_byte(8'hCC);
        send_byte(8'h41);
        checks++; if ({prescale, err_count} !== {5'd16, 8'h00}) begin errors++; $display("FAIL b2b_cfg: got pre=%0d cnt=%h want 16 00", prescale, err_count); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_config();
        test_errors();
`ifdef CTRL_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
